// File: rtl/data_memory_responder.sv
// Data-memory bus responder: word array with byte-lane writes,
// programmable wait states, registered ready/err/data and lock tracking.
module data_memory_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        clk_en,
  input  logic        req_valid,
  input  logic [29:0] address_in,
  input  logic [31:0] data_in,
  input  logic [3:0]  mask_in,
  input  logic        memory_mode,
  input  logic        bus_lock,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic        lock_held
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic HAS_WAIT = (WAIT_STATES > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;

  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic        mode_q;
  logic        oor;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign accept = clk_en && (state == S_IDLE) && req_valid;
  assign oor    = (addr_q >= 30'(DEPTH));
  assign idx    = addr_q[AW-1:0];
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (HAS_WAIT) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WS;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request fields are captured once so later bus changes are ignored.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      mode_q    <= 1'b0;
      lock_held <= 1'b0;
    end else if (accept) begin
      addr_q    <= address_in;
      data_q    <= data_in;
      mask_q    <= mask_in;
      mode_q    <= memory_mode;
      lock_held <= bus_lock;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      ready    <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else if (clk_en) begin
      ready <= (state == S_RESP);
      err   <= (state == S_RESP) && oor;
      if (state == S_RESP) begin
        if (oor) begin
          data_out <= '0;
        end else if (!mode_q) begin
          data_out <= mem[idx];
        end
      end
    end
  end

  // Array is never reset; writes commit only when the access completes.
  always_ff @(posedge clk) begin
    if (clk_en && (state == S_RESP) && mode_q && !oor) begin
      if (mask_q[3]) mem[idx][31:24] <= data_q[31:24];
      if (mask_q[2]) mem[idx][23:16] <= data_q[23:16];
      if (mask_q[1]) mem[idx][15:8]  <= data_q[15:8];
      if (mask_q[0]) mem[idx][7:0]   <= data_q[7:0];
    end
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Bus-side responder for the core's data-memory port: accepts the word address, lane-ordered write data, byte mask, mode and lock from the execute stage.
- Services each access from an internal word array with a programmable number of wait states.
- Returns a registered read word, a ready strobe and an error flag to the load path.
- Lane convention: byte offset 0 occupies bits 31:24 and is enabled by mask[3].

Parameters:
DEPTH, 1024, number of 32-bit words in the array; legal word addresses are 0..DEPTH-1.
WAIT_STATES, 0, extra cycles between request acceptance and ready; range 0..15.

Ports:
clk  input  1  clock; all state changes on rising edge
async_rst  input  1  asynchronous reset, active-high
clk_en  input  1  when low, all state (FSM, counter, outputs, array) holds
req_valid  input  1  master request; held high with stable fields until ready
address_in  input  30  word address
data_in  input  32  write data, lane ordered (offset 0 = bits 31:24)
mask_in  input  4  byte enables; mask_in[3] = bits 31:24 ... mask_in[0] = bits 7:0
memory_mode  input  1  1 = write, 0 = read
bus_lock  input  1  request belongs to a locked sequence
data_out  output  32  read data, lane ordered; valid when ready=1
ready  output  1  one-cycle completion strobe
err  output  1  valid with ready; address out of range
busy  output  1  high in WAIT and RESP
lock_held  output  1  lock state for an external arbiter

Behaviour:
- Reset (async assert): FSM=IDLE, wait counter=0, data_out=0, ready=0, err=0, busy=0, lock_held=0. Array contents are not cleared. Any in-flight access is discarded; a pending write is not committed.
- FSM states: IDLE, WAIT, RESP. All transitions are qualified by clk_en.
- IDLE:
  - On req_valid=1, latch address_in, data_in, mask_in, memory_mode, bus_lock.
  - Go to WAIT with counter=WAIT_STATES if WAIT_STATES>0; otherwise go directly to RESP.
  - req_valid=0: stay in IDLE.
- WAIT: decrement the counter each enabled cycle. When the counter reaches 1 and decrements, go to RESP. Total cycles spent in WAIT = WAIT_STATES.
- RESP:
  - ready=1 and err are registered outputs for exactly this one cycle; next state is IDLE.
  - Write: on entry to RESP, each byte lane with latched mask bit set is written to the array; other lanes are untouched. mask=0 writes nothing and completes normally.
  - Read: data_out is loaded with the full word on entry to RESP; mask is ignored.
- Latency: request accepted at edge N; ready high during the cycle after edge N+1+WAIT_STATES. The next request can be accepted no earlier than the edge after the ready cycle, so throughput is one access per WAIT_STATES+2 cycles.
- data_out holds its value after a read until the next read completes. Writes do not modify data_out.
- Out of range (latched address >= DEPTH): same timing, err=1 with ready, no array write, data_out=0.
- Lock:
  - lock_held is updated at acceptance: set if the latched bus_lock=1, cleared if it is 0.
  - Persists through IDLE; only reset or an unlocked access clears it.
  - The responder enforces nothing further.
- busy = (state != IDLE).
- clk_en=0 in any state: counter, state and outputs freeze. A ready that is already asserted stays asserted until the next enabled edge.
- Protocol violation: changes to req fields after acceptance are ignored, because fields are latched.
- req_valid dropping mid-access does not abort the access.

Test Plan:
1. WAIT_STATES=0: write addr 5, data 0x11223344, mask 1111; then read addr 5 -> ready in cycle after acceptance for both; read data_out=0x11223344, err=0.
2. Byte/half masks: preload addr 7 = 0xAABBCCDD; write data 0x00EE0000 mask 0100, then 0x00001122 mask 0011 -> read addr 7 returns 0xAAEE1122.
3. WAIT_STATES=3: read accepted at edge N -> ready exactly one cycle, high after edge N+4; busy high for 4 cycles; no second acceptance before the following edge.
4. Out of range, DEPTH=1024: write 0xDEADBEEF to addr 1024 -> ready with err=1, data_out=0; read addr 0 is unchanged.
5. Lock: read with bus_lock=1 -> lock_held=1 after acceptance; idle 5 cycles, still 1; write with bus_lock=0 -> lock_held=0.
6. Reset and stall, WAIT_STATES=2:
   - Assert async_rst mid-WAIT during a write to addr 3 (old value 0x0) -> outputs 0 immediately, addr 3 reads 0x0.
   - clk_en low for 3 cycles in WAIT -> ready delayed by exactly 3 cycles.
